// File: rtl/apb_requester_if.sv
// APB bus bundle between the requester and the peripheral completers.
//   paddr/pdata/psel/penable/pwrite/pstb : driven by the requester (master)
//   prdata/pready/perr                   : driven by the completer (slave)
`timescale 1ns/1ps
interface apb_requester_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [3:0]            pstb;
    logic                  pready;
    logic                  perr;

    modport master (
        output paddr, pdata, psel, penable, pwrite, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, psel, penable, pwrite, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: turns one CPU load/store request into an
// APB SETUP/ACCESS transfer and returns completion, error and read data.
//   pclk, reset              : clock, synchronous active-high reset
//   cpu_req/addr/wdata/we/stb: CPU request, sampled only while idle
//   cpu_rdata                : last read data, held until the next read completes
//   cpu_done, cpu_err        : one-cycle completion pulse and its error flag
//   apb                      : APB bus (master modport)
//   apb_perr                 : one-cycle pulse on slave error or timeout
`timescale 1ns/1ps
module apb_requester #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_stb,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_err,
    apb_requester_if.master       apb,
    output logic                  apb_perr
);

    // TIMEOUT=0 would give a zero-width counter; keep at least one bit.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT != 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [3:0]            pstb_q, pstb_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  aperr_q, aperr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pdata_d   = pdata_q;
        rdata_d   = rdata_q;
        pwrite_d  = pwrite_q;
        pstb_d    = pstb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        cnt_d     = cnt_q;
        // Completion flags are pulses: low unless set this cycle.
        done_d    = 1'b0;
        err_d     = 1'b0;
        aperr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    paddr_d   = cpu_addr;
                    pdata_d   = cpu_wdata;
                    pwrite_d  = cpu_we;
                    pstb_d    = cpu_we ? cpu_stb : 4'b0000;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                // pready is checked first so it wins over a same-edge timeout.
                if (apb.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (!pwrite_q) begin
                        rdata_d = apb.prdata;
                    end
                    done_d  = 1'b1;
                    err_d   = apb.perr;
                    aperr_d = apb.perr;
                    state_d = StIdle;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    aperr_d   = 1'b1;
                    state_d   = StIdle;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= StIdle;
            paddr_q   <= '0;
            pdata_q   <= '0;
            rdata_q   <= '0;
            pwrite_q  <= 1'b0;
            pstb_q    <= 4'b0000;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aperr_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
            rdata_q   <= rdata_d;
            pwrite_q  <= pwrite_d;
            pstb_q    <= pstb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aperr_q   <= aperr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pdata   = pdata_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pstb    = pstb_q;
    assign cpu_rdata   = rdata_q;
    assign cpu_done    = done_q;
    assign cpu_err     = err_q;
    assign apb_perr    = aperr_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: two instances (default timeout, and TIMEOUT=4),
// directed and random transfers checked cycle by cycle against a transaction
// model computed from wait count, timeout and error rules.
`timescale 1ns/1ps
module tb_apb_requester;

    localparam int TO_A = 255;
    localparam int TO_B = 4;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req_a = 1'b0;
    logic        cpu_req_b = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_stb = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        done_a, done_b, err_a, err_b, aperr_a, aperr_b;

    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_A)) dut_a (
        .pclk(pclk), .reset(reset), .cpu_req(cpu_req_a), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_stb(cpu_stb), .cpu_rdata(rdata_a),
        .cpu_done(done_a), .cpu_err(err_a), .apb(bus_a), .apb_perr(aperr_a)
    );

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_B)) dut_b (
        .pclk(pclk), .reset(reset), .cpu_req(cpu_req_b), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_stb(cpu_stb), .cpu_rdata(rdata_b),
        .cpu_done(done_b), .cpu_err(err_b), .apb(bus_b), .apb_perr(aperr_b)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;
    int txn_id = 0;

    logic [31:0] rd_model [2];

    logic        o_psel, o_pen, o_pwrite, o_done, o_err, o_aperr;
    logic [31:0] o_paddr, o_pdata, o_rdata;
    logic [3:0]  o_pstb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (txn %0d): observed=%0h expected=%0h", tag, txn_id, obs, exp);
        end
    endtask

    task automatic sample(input bit sel);
        if (sel) begin
            o_psel = bus_b.psel; o_pen = bus_b.penable; o_pwrite = bus_b.pwrite;
            o_paddr = bus_b.paddr; o_pdata = bus_b.pdata; o_pstb = bus_b.pstb;
            o_rdata = rdata_b; o_done = done_b; o_err = err_b; o_aperr = aperr_b;
        end else begin
            o_psel = bus_a.psel; o_pen = bus_a.penable; o_pwrite = bus_a.pwrite;
            o_paddr = bus_a.paddr; o_pdata = bus_a.pdata; o_pstb = bus_a.pstb;
            o_rdata = rdata_a; o_done = done_a; o_err = err_a; o_aperr = aperr_a;
        end
    endtask

    task automatic check_ctl(input string tag, input bit psel, input bit pen,
                             input bit done, input bit err, input bit aperr);
        chk({tag, ".psel"}, 64'(o_psel), 64'(psel));
        chk({tag, ".penable"}, 64'(o_pen), 64'(pen));
        chk({tag, ".cpu_done"}, 64'(o_done), 64'(done));
        chk({tag, ".cpu_err"}, 64'(o_err), 64'(err));
        chk({tag, ".apb_perr"}, 64'(o_aperr), 64'(aperr));
    endtask

    task automatic check_bus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input bit we, input logic [3:0] stb);
        chk({tag, ".paddr"}, 64'(o_paddr), 64'(addr));
        chk({tag, ".pdata"}, 64'(o_pdata), 64'(data));
        chk({tag, ".pwrite"}, 64'(o_pwrite), 64'(we));
        chk({tag, ".pstb"}, 64'(o_pstb), 64'(stb));
    endtask

    task automatic check_zero(input string tag);
        check_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_bus(tag, 32'h0, 32'h0, 1'b0, 4'h0);
        chk({tag, ".cpu_rdata"}, 64'(o_rdata), 64'h0);
    endtask

    task automatic set_req(input bit sel, input bit v);
        if (sel) cpu_req_b = v;
        else     cpu_req_a = v;
    endtask

    // Random completer activity; only matters while a DUT is in ACCESS.
    task automatic noise();
        bus_a.pready = 1'($urandom); bus_a.perr = 1'($urandom); bus_a.prdata = $urandom;
        bus_b.pready = 1'($urandom); bus_b.perr = 1'($urandom); bus_b.prdata = $urandom;
    endtask

    task automatic set_resp(input bit sel, input bit rdy, input bit err, input logic [31:0] d);
        if (sel) begin bus_b.pready = rdy; bus_b.perr = err; bus_b.prdata = d; end
        else     begin bus_a.pready = rdy; bus_a.perr = err; bus_a.prdata = d; end
    endtask

    // One transfer on DUT sel: gap idle cycles, request, SETUP, then the completer
    // holds pready low for 'waits' ACCESS cycles. hold keeps cpu_req high after the
    // request; rst_at >= 0 resets during that ACCESS cycle instead of completing.
    task automatic run_txn(input bit sel, input int gap, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] stb,
                           input logic [31:0] rd, input bit pe, input int waits,
                           input bit hold, input int rst_at);
        int t;
        int k;
        bit tmo;
        logic [3:0] xstb;
        t    = sel ? TO_B : TO_A;
        tmo  = (t != 0) && (waits >= t);
        k    = tmo ? t : waits + 1;
        xstb = we ? stb : 4'h0;
        txn_id++;

        set_req(sel, 1'b0);
        for (int g = 0; g < gap; g++) begin
            noise();
            @(negedge pclk);
            sample(sel);
            check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        cpu_addr = addr; cpu_wdata = wdata; cpu_we = we; cpu_stb = stb;
        set_req(sel, 1'b1);
        noise();
        @(negedge pclk);
        sample(sel);
        check_ctl("setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_bus("setup", addr, wdata, we, xstb);
        chk("setup.cpu_rdata", 64'(o_rdata), 64'(rd_model[sel]));

        // Request inputs now change freely; they must be ignored.
        set_req(sel, hold);
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom); cpu_stb = 4'($urandom);
        noise();
        @(negedge pclk);
        sample(sel);
        check_ctl("access", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_bus("access", addr, wdata, we, xstb);

        for (int i = 0; i < k; i++) begin
            noise();
            if (i == rst_at) begin
                set_resp(sel, 1'b1, 1'b0, 32'hDEAD_BEEF);
                set_req(sel, 1'b0);
                reset = 1'b1;
                @(negedge pclk);
                reset = 1'b0;
                rd_model[0] = '0;
                rd_model[1] = '0;
                sample(sel);
                check_zero("reset");
                for (int j = 0; j < 4; j++) begin
                    noise();
                    @(negedge pclk);
                    sample(sel);
                    check_ctl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                return;
            end
            if (i == waits) set_resp(sel, 1'b1, pe, rd);
            else            set_resp(sel, 1'b0, 1'($urandom), $urandom);
            @(negedge pclk);
            sample(sel);
            if (i < k - 1) begin
                check_ctl("wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                check_bus("wait", addr, wdata, we, xstb);
            end else begin
                check_ctl(tmo ? "timeout" : "done", 1'b0, 1'b0, 1'b1, tmo | pe, tmo | pe);
                if (!we && !tmo) rd_model[sel] = rd;
                chk("done.cpu_rdata", 64'(o_rdata), 64'(rd_model[sel]));
            end
        end
        noise();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_addr, r_wdata, r_rd;
        bit          r_we, r_pe;
        rd_model[0] = '0;
        rd_model[1] = '0;
        noise();
        repeat (3) @(negedge pclk);
        sample(1'b0); check_zero("rst_a");
        sample(1'b1); check_zero("rst_b");
        reset = 1'b0;

        // Directed: read, write, wait states with slave error.
        run_txn(1'b0, 1, 1'b0, 32'h2000_0004, 32'h1234_5678, 4'hA, 32'h0000_00FF, 1'b0, 0, 1'b0, -1);
        run_txn(1'b0, 1, 1'b1, 32'h2000_0000, 32'h0000_0002, 4'hF, 32'h5555_AAAA, 1'b0, 0, 1'b0, -1);
        run_txn(1'b0, 2, 1'b1, 32'h2000_0008, 32'hCAFE_F00D, 4'h3, 32'h0BAD_0BAD, 1'b1, 5, 1'b0, -1);

        // cpu_req held high: back-to-back with one IDLE cycle between transfers.
        run_txn(1'b0, 1, 1'b0, 32'h2000_0010, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1, 1'b1, -1);
        run_txn(1'b0, 0, 1'b1, 32'h2000_0014, 32'h2222_2222, 4'h5, 32'h0, 1'b0, 0, 1'b1, -1);
        run_txn(1'b0, 0, 1'b0, 32'h2000_0018, 32'h0, 4'hF, 32'h3333_3333, 1'b0, 2, 1'b0, -1);

        // Timeout instance: abort, recovery, and pready on the last allowed cycle.
        run_txn(1'b1, 1, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h4444_4444, 1'b0, 10, 1'b0, -1);
        run_txn(1'b1, 0, 1'b0, 32'h3000_0004, 32'h0, 4'h0, 32'h6666_6666, 1'b0, 0, 1'b0, -1);
        run_txn(1'b1, 1, 1'b0, 32'h3000_0008, 32'h0, 4'h0, 32'h7777_7777, 1'b0, TO_B - 1, 1'b0, -1);
        run_txn(1'b1, 1, 1'b1, 32'h3000_000C, 32'h8888_8888, 4'h9, 32'h0, 1'b1, TO_B, 1'b0, -1);

        // Random transfers on both instances.
        for (int n = 0; n < 40; n++) begin
            r_addr = $urandom; r_wdata = $urandom; r_rd = $urandom;
            r_we = 1'($urandom); r_pe = ($urandom_range(0, 3) == 0);
            run_txn(1'(n % 2), $urandom_range(0, 2), r_we, r_addr, r_wdata, 4'($urandom), r_rd,
                    r_pe, $urandom_range(0, 7), 1'b0, -1);
        end

        // Make sure read data is non-zero, then reset mid-ACCESS and recover.
        run_txn(1'b0, 1, 1'b0, 32'h2000_0020, 32'h0, 4'h0, 32'h9999_9999, 1'b0, 0, 1'b0, -1);
        run_txn(1'b0, 1, 1'b1, 32'h2000_0024, 32'hABCD_0123, 4'hC, 32'h0, 1'b0, 20, 1'b0, 3);
        run_txn(1'b0, 0, 1'b0, 32'h2000_0028, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 1, 1'b0, -1);

        @(negedge pclk);
        sample(1'b0);
        check_ctl("final", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
